// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder buffer.
//   TAG_W       - tag width, matches the register file dependency width
//   DEPTH       - number of entries, 2**TAG_W
//   rob_type_e  - instruction class recorded at issue
//   rob_entry_t - per-entry bookkeeping held in the circular queue
package rob_pkg;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned DEPTH = 32;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_BRANCH = 2'd1,
        ROB_STORE  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   typ;
        logic        has_rd;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mispredict;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: bundles every non-clock signal of the reorder buffer.
//   issue_*   - decoder allocation handshake (valid/type/rd in, ready/tag out)
//   wb_*      - common data bus result delivery
//   q1_*/q2_* - operand forwarding queries from the register file
//   commit_*  - register file write port driven at retirement
//   store_commit, flush, flush_pc - store release and mispredict redirect
// master: decoder/CDB/register-file side.  slave: the reorder buffer.
interface reorder_buffer_if #(
    parameter int unsigned TAG_W = rob_pkg::TAG_W
);

    logic             issue_valid;
    logic [1:0]       issue_type;
    logic             issue_has_rd;
    logic [4:0]       issue_rd;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;

    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_val;
    logic             wb_mispredict;
    logic [31:0]      wb_target;

    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_ready;
    logic             q2_ready;
    logic [31:0]      q1_val;
    logic [31:0]      q2_val;

    logic             commit_en;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_val;
    logic             store_commit;
    logic             flush;
    logic [31:0]      flush_pc;

    modport master (
        output issue_valid, issue_type, issue_has_rd, issue_rd,
        output wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
        output q1_tag, q2_tag,
        input  issue_ready, issue_tag,
        input  q1_ready, q2_ready, q1_val, q2_val,
        input  commit_en, commit_tag, commit_rd, commit_val,
        input  store_commit, flush, flush_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_has_rd, issue_rd,
        input  wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
        input  q1_tag, q2_tag,
        output issue_ready, issue_tag,
        output q1_ready, q2_ready, q1_val, q2_val,
        output commit_en, commit_tag, commit_rd, commit_val,
        output store_commit, flush, flush_pc
    );

endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - reorder_buffer_if.slave carrying issue, writeback, forwarding
//              queries, commit, store release and flush/redirect
// Tags are allocated at tail, results land out of order from the CDB, and
// the head entry retires once per cycle when it holds a result. A retiring
// mispredicted branch flushes the whole queue at the following edge.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = rob_pkg::DEPTH,
    parameter int unsigned TAG_W = rob_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);

    rob_entry_t       ent_q [DEPTH];
    rob_entry_t       ent_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    rob_entry_t       head_ent;
    logic             retire;
    logic             do_flush;
    logic             issue_ok;
    logic             accept;
    logic             wb_live;
    logic             q1_wb, q1_st;
    logic             q2_wb, q2_st;

    always_comb begin
        head_ent = ent_q[head_q];
        retire   = head_ent.busy && head_ent.ready;
        do_flush = retire && (head_ent.typ == ROB_BRANCH) && head_ent.mispredict;
        // A slot freed by this cycle's retirement is not reusable until the next cycle.
        issue_ok = (count_q != (TAG_W+1)'(DEPTH)) && !do_flush;
        accept   = bus.issue_valid && issue_ok;
    end

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) begin
                ent_d[tail_q] = '{busy:       1'b1,
                                  ready:      1'b0,
                                  typ:        rob_type_e'(bus.issue_type),
                                  has_rd:     bus.issue_has_rd,
                                  rd:         bus.issue_rd,
                                  val:        '0,
                                  mispredict: 1'b0,
                                  target:     '0};
                tail_d = tail_q + TAG_W'(1);
            end
            // Busy is tested on the registered array so a result for the slot being
            // allocated this cycle is discarded rather than attached to the new entry.
            if (bus.wb_valid && ent_q[bus.wb_tag].busy) begin
                ent_d[bus.wb_tag].ready      = 1'b1;
                ent_d[bus.wb_tag].val        = bus.wb_val;
                ent_d[bus.wb_tag].mispredict = bus.wb_mispredict;
                ent_d[bus.wb_tag].target     = bus.wb_target;
            end
            if (retire) begin
                ent_d[head_q].busy  = 1'b0;
                ent_d[head_q].ready = 1'b0;
                head_d = head_q + TAG_W'(1);
            end
            case ({accept, retire})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        bus.issue_ready  = issue_ok;
        bus.issue_tag    = tail_q;
        bus.commit_en    = retire && ((head_ent.typ == ROB_REG) || head_ent.has_rd);
        bus.commit_tag   = retire ? head_q : '0;
        bus.commit_rd    = bus.commit_en ? head_ent.rd : '0;
        bus.commit_val   = bus.commit_en ? head_ent.val : '0;
        bus.store_commit = retire && (head_ent.typ == ROB_STORE);
        bus.flush        = do_flush;
        bus.flush_pc     = do_flush ? head_ent.target : '0;
    end

    // Forwarding: a result on the CDB this cycle beats the stored copy. The CDB
    // path is masked during reset so every query reads not-ready while held.
    always_comb begin
        wb_live      = bus.wb_valid && !rst;
        q1_wb        = wb_live && (bus.wb_tag == bus.q1_tag);
        q1_st        = ent_q[bus.q1_tag].busy && ent_q[bus.q1_tag].ready;
        q2_wb        = wb_live && (bus.wb_tag == bus.q2_tag);
        q2_st        = ent_q[bus.q2_tag].busy && ent_q[bus.q2_tag].ready;
        bus.q1_ready = q1_wb || q1_st;
        bus.q2_ready = q2_wb || q2_st;
        bus.q1_val   = q1_wb ? bus.wb_val : (q1_st ? ent_q[bus.q1_tag].val : '0);
        bus.q2_val   = q2_wb ? bus.wb_val : (q2_st ? ent_q[bus.q2_tag].val : '0);
    end

endmodule
